// File: rtl/lumos_mem_pkg.sv
// Shared encodings for the LumosRV data-memory access path: store sizes,
// load types, controller states and the alignment rule.
package lumos_mem_pkg;

  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_SB   = 2'b01;
  localparam logic [1:0] SZ_SH   = 2'b10;
  localparam logic [1:0] SZ_SW   = 2'b11;

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LH  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RSP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // A store size overrides the load type; unknown load types align like lw.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [2:0] ld,
                                         input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    if (size == SZ_SW) begin
      mis = (lo != 2'b00);
    end else if (size == SZ_SH) begin
      mis = lo[0];
    end else if (size == SZ_NONE) begin
      if (ld == LD_LH || ld == LD_LHU) begin
        mis = lo[0];
      end else if (ld == LD_LB || ld == LD_LBU) begin
        mis = 1'b0;
      end else begin
        mis = (lo != 2'b00);
      end
    end
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_extend
  import lumos_mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  mem_read,
  input  logic [31:0] rsp_rdata,
  output logic [31:0] ext_data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rsp_rdata >> {addr_lo, 3'b000};
    case (mem_read)
      LD_LB:   ext_data = {{24{shifted[7]}}, shifted[7:0]};
      LD_LH:   ext_data = {{16{shifted[15]}}, shifted[15:0]};
      LD_LBU:  ext_data = {24'd0, shifted[7:0]};
      LD_LHU:  ext_data = {16'd0, shifted[15:0]};
      default: ext_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences one data-memory load or store over a valid/ready port, stalling
// the core until the access completes or errors.
module mem_access_ctrl
  import lumos_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  mem_write,
  input  logic        mem_load,
  input  logic [2:0]  mem_read,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] load_data,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_rdata
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [2:0]  rd_q, rd_d;
  logic        write_q, write_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] load_data_q, load_data_d;
  logic        bus_valid_q, bus_valid_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;

  logic        access;
  logic        misal;
  logic [31:0] ext_data;

  assign access = (mem_write != SZ_NONE) || mem_load;
  assign misal  = is_misaligned(mem_write, mem_read, addr[1:0]);

  load_extend u_load_extend (
    .addr_lo   (addr_lo_q),
    .mem_read  (rd_q),
    .rsp_rdata (rsp_rdata),
    .ext_data  (ext_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_lo_d   = addr_lo_q;
    rd_d        = rd_q;
    write_d     = write_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    load_data_d = load_data_q;
    bus_valid_d = bus_valid_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (start && access) begin
          addr_lo_d = addr[1:0];
          rd_d      = mem_read;
          write_d   = (mem_write != SZ_NONE);
          if (misal) begin
            state_d     = ST_DONE;
            done_d      = 1'b1;
            err_d       = 1'b1;
            load_data_d = '0;
          end else begin
            state_d     = ST_REQ;
            bus_valid_d = 1'b1;
            bus_we_d    = (mem_write != SZ_NONE);
            bus_addr_d  = {addr[31:2], 2'b00};
            case (mem_write)
              SZ_SB: begin
                bus_be_d    = 4'b0001 << addr[1:0];
                bus_wdata_d = {4{wdata[7:0]}};
              end
              SZ_SH: begin
                bus_be_d    = addr[1] ? 4'b1100 : 4'b0011;
                bus_wdata_d = {2{wdata[15:0]}};
              end
              SZ_SW: begin
                bus_be_d    = 4'b1111;
                bus_wdata_d = wdata;
              end
              default: begin
                bus_be_d    = 4'b1111;
                bus_wdata_d = '0;
              end
            endcase
          end
        end
      end
      ST_REQ: begin
        if (bus_ready) begin
          bus_valid_d = 1'b0;
          if (write_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RSP;
            cnt_d   = '0;
          end
        end
      end
      ST_RSP: begin
        // A response on the expiry cycle still wins over the timeout.
        if (rsp_valid) begin
          state_d     = ST_DONE;
          done_d      = 1'b1;
          load_data_d = ext_data;
        end else if (cnt_q == TO_LAST) begin
          state_d     = ST_DONE;
          done_d      = 1'b1;
          err_d       = 1'b1;
          load_data_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_lo_q   <= '0;
      rd_q        <= '0;
      write_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      load_data_q <= '0;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_lo_q   <= addr_lo_d;
      rd_q        <= rd_d;
      write_q     <= write_d;
      done_q      <= done_d;
      err_q       <= err_d;
      load_data_q <= load_data_d;
      bus_valid_q <= bus_valid_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  // The core advances on the done cycle, so DONE itself does not stall.
  assign stall = ((state_q == ST_IDLE) && start && access) ||
                 (state_q == ST_REQ) || (state_q == ST_RSP);

  assign done      = done_q;
  assign err       = err_q;
  assign load_data = load_data_q;
  assign bus_valid = bus_valid_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: expected bus requests and completions
// are queued at issue time and a negedge monitor pops and compares them.
module tb_mem_access_ctrl;

  typedef struct {
    logic        err;
    logic        chk_data;
    logic [31:0] data;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic        chk_wdata;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mem_write;
  logic        mem_load;
  logic [2:0]  mem_read;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic        err;
  logic [31:0] load_data;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;

  int   n_cmp = 0;
  int   n_bad = 0;
  rsp_t exp_rsp[$];
  req_t exp_req[$];

  mem_access_ctrl #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mem_write (mem_write),
    .mem_load  (mem_load),
    .mem_read  (mem_read),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .done      (done),
    .err       (err),
    .load_data (load_data),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Completion and bus-handshake scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (exp_rsp.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          rsp_t r;
          r = exp_rsp.pop_front();
          checkOutput("rsp_err", {31'd0, err}, {31'd0, r.err});
          if (r.chk_data) checkOutput("rsp_load_data", load_data, r.data);
        end
      end
      if (bus_valid && bus_ready) begin
        if (exp_req.size() == 0) begin
          checkOutput("unexpected_bus_req", 32'd1, 32'd0);
        end else begin
          req_t q;
          q = exp_req.pop_front();
          checkOutput("req_addr", bus_addr, q.addr);
          checkOutput("req_be", {28'd0, bus_be}, {28'd0, q.be});
          checkOutput("req_we", {31'd0, bus_we}, {31'd0, q.we});
          if (q.chk_wdata) checkOutput("req_wdata", bus_wdata, q.wdata);
        end
      end
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_stall"}, {31'd0, stall}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_err"}, {31'd0, err}, 32'd0);
    checkOutput({tag, "_bus_valid"}, {31'd0, bus_valid}, 32'd0);
    checkOutput({tag, "_bus_we"}, {31'd0, bus_we}, 32'd0);
    checkOutput({tag, "_load_data"}, load_data, 32'd0);
    checkOutput({tag, "_bus_addr"}, bus_addr, 32'd0);
    checkOutput({tag, "_bus_be"}, {28'd0, bus_be}, 32'd0);
    checkOutput({tag, "_bus_wdata"}, bus_wdata, 32'd0);
  endtask

  // Presents one start cycle in IDLE; returns one cycle later with start low.
  task automatic applyStimulus(input logic [1:0] ws, input logic ld, input logic [2:0] rd,
                               input logic [31:0] a, input logic [31:0] wd, input logic exp_stall);
    start     = 1'b1;
    mem_write = ws;
    mem_load  = ld;
    mem_read  = rd;
    addr      = a;
    wdata     = wd;
    #1;
    checkOutput("stall_on_start", {31'd0, stall}, {31'd0, exp_stall});
    @(posedge clk);
    #1;
    start     = 1'b0;
    mem_write = 2'b00;
    mem_load  = 1'b0;
  endtask

  task automatic doStore(input logic [1:0] ws, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input logic [31:0] bw);
    bus_ready = 1'b1;
    exp_req.push_back('{addr: {a[31:2], 2'b00}, be: be, we: 1'b1, chk_wdata: 1'b1, wdata: bw});
    exp_rsp.push_back('{err: 1'b0, chk_data: 1'b0, data: 32'd0});
    applyStimulus(ws, 1'b0, 3'b000, a, wd, 1'b1);
    checkOutput("st_c1_bus_valid", {31'd0, bus_valid}, 32'd1);
    checkOutput("st_c1_stall", {31'd0, stall}, 32'd1);
    tick();
    bus_ready = 1'b0;
    checkOutput("st_c2_done", {31'd0, done}, 32'd1);
    checkOutput("st_c2_stall", {31'd0, stall}, 32'd0);
    tick();
    checkOutput("st_c3_done", {31'd0, done}, 32'd0);
  endtask

  task automatic doLoad(input logic [2:0] rd, input logic [31:0] a,
                        input logic [31:0] rdata, input logic [31:0] exp_data);
    bus_ready = 1'b1;
    exp_req.push_back('{addr: {a[31:2], 2'b00}, be: 4'b1111, we: 1'b0, chk_wdata: 1'b0, wdata: 32'd0});
    exp_rsp.push_back('{err: 1'b0, chk_data: 1'b1, data: exp_data});
    applyStimulus(2'b00, 1'b1, rd, a, 32'd0, 1'b1);
    checkOutput("ld_c1_bus_valid", {31'd0, bus_valid}, 32'd1);
    tick();
    bus_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_rdata = rdata;
    tick();
    rsp_valid = 1'b0;
    checkOutput("ld_c3_done", {31'd0, done}, 32'd1);
    checkOutput("ld_c3_stall", {31'd0, stall}, 32'd0);
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    mem_write = 2'b00;
    mem_load  = 1'b0;
    mem_read  = 3'b000;
    addr      = 32'd0;
    wdata     = 32'd0;
    bus_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = 32'd0;
    repeat (2) tick();
    checkResetOutputs("reset");
    rst = 1'b0;
    tick();

    // Stores: byte, half and word lane placement.
    doStore(2'b01, 32'h0000_1003, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);
    doStore(2'b10, 32'h0000_5002, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF);
    doStore(2'b10, 32'h0000_5000, 32'h1234_BEEF, 4'b0011, 32'hBEEF_BEEF);
    doStore(2'b11, 32'h0000_5004, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

    // Loads from the same word with every extension type.
    doLoad(3'b001, 32'h0000_2003, 32'h80FF_7F01, 32'hFFFF_FF80);
    doLoad(3'b100, 32'h0000_2002, 32'h80FF_7F01, 32'h0000_80FF);
    doLoad(3'b001, 32'h0000_2001, 32'h80FF_7F01, 32'h0000_007F);
    doLoad(3'b010, 32'h0000_2002, 32'h80FF_7F01, 32'hFFFF_80FF);
    doLoad(3'b010, 32'h0000_2000, 32'h80FF_7F01, 32'h0000_7F01);
    doLoad(3'b011, 32'h0000_2000, 32'h80FF_7F01, 32'h0000_0001);
    doLoad(3'b000, 32'h0000_2000, 32'h80FF_7F01, 32'h80FF_7F01);
    doLoad(3'b111, 32'h0000_2004, 32'h80FF_7F01, 32'h80FF_7F01);

    // Misaligned accesses finish in one cycle with no bus request.
    bus_ready = 1'b1;
    exp_rsp.push_back('{err: 1'b1, chk_data: 1'b0, data: 32'd0});
    applyStimulus(2'b11, 1'b0, 3'b000, 32'h0000_3002, 32'h1111_1111, 1'b1);
    checkOutput("mis_sw_done", {31'd0, done}, 32'd1);
    checkOutput("mis_sw_bus_valid", {31'd0, bus_valid}, 32'd0);
    tick();
    checkOutput("mis_sw_c2_bus_valid", {31'd0, bus_valid}, 32'd0);
    exp_rsp.push_back('{err: 1'b1, chk_data: 1'b0, data: 32'd0});
    applyStimulus(2'b00, 1'b1, 3'b010, 32'h0000_3001, 32'd0, 1'b1);
    checkOutput("mis_lh_done", {31'd0, done}, 32'd1);
    checkOutput("mis_lh_bus_valid", {31'd0, bus_valid}, 32'd0);
    tick();
    bus_ready = 1'b0;

    // No-op start and spurious response while idle.
    rsp_valid = 1'b1;
    applyStimulus(2'b00, 1'b0, 3'b000, 32'h0000_0010, 32'd0, 1'b0);
    rsp_valid = 1'b0;
    checkOutput("noop_bus_valid", {31'd0, bus_valid}, 32'd0);
    checkOutput("noop_stall", {31'd0, stall}, 32'd0);
    tick();
    checkOutput("noop_done", {31'd0, done}, 32'd0);

    // Backpressure: request held stable for three refused cycles.
    exp_req.push_back('{addr: 32'h0000_4000, be: 4'b1111, we: 1'b0, chk_wdata: 1'b0, wdata: 32'd0});
    exp_rsp.push_back('{err: 1'b0, chk_data: 1'b1, data: 32'h1122_3344});
    applyStimulus(2'b00, 1'b1, 3'b000, 32'h0000_4000, 32'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_bus_valid", {31'd0, bus_valid}, 32'd1);
      checkOutput("bp_bus_addr", bus_addr, 32'h0000_4000);
      checkOutput("bp_stall", {31'd0, stall}, 32'd1);
      tick();
    end
    bus_ready = 1'b1;
    checkOutput("bp_accept_valid", {31'd0, bus_valid}, 32'd1);
    tick();
    bus_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_rdata = 32'h1122_3344;
    checkOutput("bp_rsp_stall", {31'd0, stall}, 32'd1);
    tick();
    rsp_valid = 1'b0;
    checkOutput("bp_done", {31'd0, done}, 32'd1);
    tick();

    // Timeout with no response: four RSP cycles, then done+err.
    bus_ready = 1'b1;
    exp_req.push_back('{addr: 32'h0000_6000, be: 4'b1111, we: 1'b0, chk_wdata: 1'b0, wdata: 32'd0});
    exp_rsp.push_back('{err: 1'b1, chk_data: 1'b1, data: 32'd0});
    applyStimulus(2'b00, 1'b1, 3'b000, 32'h0000_6000, 32'd0, 1'b1);
    tick();
    bus_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("to_wait_done", {31'd0, done}, 32'd0);
      checkOutput("to_wait_stall", {31'd0, stall}, 32'd1);
      tick();
    end
    checkOutput("to_done", {31'd0, done}, 32'd1);
    checkOutput("to_err", {31'd0, err}, 32'd1);
    tick();

    // Response on the expiry cycle beats the timeout.
    bus_ready = 1'b1;
    exp_req.push_back('{addr: 32'h0000_6008, be: 4'b1111, we: 1'b0, chk_wdata: 1'b0, wdata: 32'd0});
    exp_rsp.push_back('{err: 1'b0, chk_data: 1'b1, data: 32'hDEAD_BEEF});
    applyStimulus(2'b00, 1'b1, 3'b000, 32'h0000_6008, 32'd0, 1'b1);
    tick();
    bus_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rsp_valid = 1'b1;
    rsp_rdata = 32'hDEAD_BEEF;
    tick();
    rsp_valid = 1'b0;
    checkOutput("to_race_done", {31'd0, done}, 32'd1);
    checkOutput("to_race_err", {31'd0, err}, 32'd0);
    tick();

    // Reset while waiting in RSP abandons the access.
    bus_ready = 1'b1;
    exp_req.push_back('{addr: 32'h0000_7000, be: 4'b1111, we: 1'b0, chk_wdata: 1'b0, wdata: 32'd0});
    applyStimulus(2'b00, 1'b1, 3'b000, 32'h0000_7000, 32'd0, 1'b1);
    tick();
    bus_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkResetOutputs("midrst");
    tick();
    checkOutput("midrst_no_done", {31'd0, done}, 32'd0);
    doLoad(3'b000, 32'h0000_7004, 32'h0BAD_F00D, 32'h0BAD_F00D);

    repeat (3) tick();
    checkOutput("rsp_queue_drained", exp_rsp.size(), 32'd0);
    checkOutput("req_queue_drained", exp_req.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multi-cycle controller that sequences data-memory loads and stores for the LumosRV core. It sits between the core's execute stage and a valid/ready data-memory port. It takes the control unit's store-size and load-type encodings, drives word-aligned bus requests with byte enables, and waits for read responses. It stalls the core until the access completes, then returns the aligned, sign- or zero-extended load data.

## Interface
- `TIMEOUT`, default 16: maximum cycles spent in RSP waiting for `rsp_valid` before the access is errored; legal range 1..255.
- `clk` in 1: clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: core requests an access this cycle; sampled only in IDLE.
- `mem_write` in 2: store size: 00 none, 01 sb, 10 sh, 11 sw.
- `mem_load` in 1: access is a load; ignored when `mem_write`≠00, so the store wins.
- `mem_read` in 3: load type: 000 lw, 001 lb, 010 lh, 011 lbu, 100 lhu; 101–111 are treated as lw.
- `addr` in 32: byte address from the ALU.
- `wdata` in 32: store data (rs2).
- `stall` out 1: core must hold the current instruction.
- `done` out 1: one-cycle pulse when the access finishes.
- `err` out 1: valid with `done`; set on a misaligned access or a timeout.
- `load_data` out 32: extended load result, valid with `done`; held until the next `done`.
- `bus_valid` out 1: request valid.
- `bus_ready` in 1: memory accepts the request.
- `bus_we` out 1: the request is a write.
- `bus_addr` out 32: {addr[31:2], 2'b00}.
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: lane-replicated store data.
- `rsp_valid` in 1: read data valid.
- `rsp_rdata` in 32: read word.

## Operation
- **States.** IDLE, REQ, RSP, DONE.
- **IDLE.**
  - `start` with `mem_write`=00 and `mem_load`=0 is a no-op: no state change and `stall` stays low.
  - Otherwise `addr`, `wdata`, `mem_write`, `mem_read` and `mem_load` are latched.
  - A misaligned access goes to DONE with `err`=1 and no bus request. Misaligned means: sw/lw with addr[1:0]≠0, or sh/lh/lhu with addr[0]=1.
  - All other accesses go to REQ.
- **REQ.**
  - `bus_valid`=1; `bus_addr`, `bus_be`, `bus_we` and `bus_wdata` are held stable until `bus_ready`.
  - On `bus_valid`&`bus_ready`: a write goes to DONE; a read goes to RSP with the timeout counter cleared.
- **RSP.**
  - On `rsp_valid`: capture the selected lane, extend it into `load_data`, then go to DONE with `err`=0.
  - Each cycle without `rsp_valid` increments the counter. When the counter reaches `TIMEOUT`, go to DONE with `err`=1; `load_data` is set to 0.
  - If `rsp_valid` arrives in the same cycle the counter expires, the response wins.
- **DONE.** `done`=1 for one cycle, then IDLE. `start` is ignored in DONE.
- **Byte enables and write data.**
  - sb: `bus_be`=1<<addr[1:0], `bus_wdata`={4{wdata[7:0]}}.
  - sh: `bus_be`=addr[1]?1100:0011, `bus_wdata`={2{wdata[15:0]}}.
  - sw: `bus_be`=1111, `bus_wdata`=wdata.
  - Reads: `bus_be`=1111.
- **Load extension.**
  - The byte or half is selected as `rsp_rdata`>>(8*addr[1:0]).
  - lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend; lw passes the word through.
- **`stall`.** `stall` = (IDLE & `start` & valid access) | REQ | RSP. It is low in DONE, so the core advances on the `done` cycle.
- **Spurious inputs.** `rsp_valid` outside RSP and `bus_ready` outside REQ are ignored.

## Timing
- **Reset.** State IDLE; counter 0. `stall`, `done`, `err`, `bus_valid` and `bus_we` are 0; `load_data`, `bus_addr`, `bus_be` and `bus_wdata` are 0.
- **Reset mid-access.** Reset in REQ or RSP abandons the transaction: `bus_valid` drops the next cycle and no `done` is generated.
- **Minimum latency** (start at cycle 0):
  - Store with `bus_ready` already high: REQ at cycle 1, `done` at cycle 2.
  - Load with `rsp_valid` the cycle after acceptance: `done` at cycle 3.
  - Misaligned access: `done`+`err` at cycle 1.
- **Timeout.** `done`+`err` arrives `TIMEOUT` cycles after entering RSP, plus one cycle for DONE.
- **Outputs.** All outputs are registered except `stall`, which is combinational from state, `start` and the access decode.

## Structure
- **Shared package `lumos_mem_pkg`:**
  - store-size encodings SB/SH/SW;
  - load-type encodings LW/LB/LH/LBU/LHU;
  - the state encoding;
  - the misalignment check as a function.
- **Sub-module `load_extend`** (combinational): takes addr[1:0], `mem_read` and `rsp_rdata`, returns the extended 32-bit value. It is instantiated once.

## Test plan
- **sb:** sb, addr=0x1003, wdata=0x000000A5, `bus_ready` high → cycle 1: `bus_addr`=0x1000, `bus_be`=1000, `bus_wdata`=0xA5A5A5A5, `bus_we`=1; cycle 2: `done`=1, `err`=0.
- **lb/lhu:** `rsp_rdata`=0x80FF7F01. lb at addr 0x2003 → `load_data`=0xFFFFFF80. lhu at addr 0x2002 → `load_data`=0x000080FF.
- **Misaligned:** sw at addr 0x3002 → no `bus_valid` ever; cycle 1: `done`=1, `err`=1.
- **Backpressure:** `bus_ready` low for 3 cycles on lw at addr 0x4000 → `bus_valid` and `bus_addr` stable through all wait cycles; `stall` high throughout; `done` arrives 2 cycles after acceptance, with `rsp_valid` given one cycle after acceptance.
- **Timeout:** `TIMEOUT`=4, no `rsp_valid` → `done`+`err` one cycle after the 4th RSP cycle, `load_data`=0. Repeat with `rsp_valid` on the expiry cycle → `err`=0 and the data is captured.
- **Reset mid-access:** assert `rst` in RSP → next cycle IDLE with all outputs at reset values; a following lw completes normally.
